// File: rtl/booth_mult_seq.sv
// Sequential signed radix-2 Booth multiplier: one add/sub/no-op plus arithmetic
// right shift per cycle, product valid WIDTH cycles after the accepted start.

module ripple_addsub #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic [WIDTH-1:0] sum
);
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] c;

    // Subtract is a + ~b + 1: invert b and feed m in as the carry.
    assign bx   = b ^ {WIDTH{m}};
    assign c[0] = m;

    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_carry
        assign c[gi+1] = (a[gi] & bx[gi]) | (c[gi] & (a[gi] ^ bx[gi]));
    end

    assign sum = a ^ bx ^ c;
endmodule

module booth_mult_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WIDTH:0] acc;
    logic [WIDTH:0] mx;
    logic [WIDTH-1:0] q;
    logic           q_1;
    logic [CW-1:0]  count;

    logic [WIDTH:0] sum;
    logic           sub_mode;
    logic [WIDTH:0] acc_upd;
    logic [WIDTH:0] acc_sh;
    logic [WIDTH-1:0] q_sh;
    logic           last;

    ripple_addsub #(.WIDTH(WIDTH + 1)) u_addsub (
        .a   (acc),
        .b   (mx),
        .m   (sub_mode),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Booth pair 10 subtracts, 01 adds; equal bits leave the accumulator alone.
    always_comb begin
        sub_mode = q[0];
        acc_upd  = (q[0] ^ q_1) ? sum : acc;
        acc_sh   = {acc_upd[WIDTH], acc_upd[WIDTH:1]};
        q_sh     = {acc_upd[0], q[WIDTH-1:1]};
        last     = (count == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mx      <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mx    <= {multiplicand[WIDTH-1], multiplicand};
                        q     <= multiplier;
                        acc   <= '0;
                        q_1   <= 1'b0;
                        count <= CW'(WIDTH);
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    acc   <= acc_sh;
                    q     <= q_sh;
                    q_1   <= q[0];
                    count <= count - CW'(1);
                    if (last) begin
                        product <= {acc_sh[WIDTH-1:0], q_sh};
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and exhaustive checks of the 4-bit sequential Booth multiplier.

module tb_booth_mult_seq;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int n_checks;
    int n_fail;

    booth_mult_seq #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] m;
        logic [3:0] q;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts one operation; returns product, negedges until done (negedge 1 follows the start edge), busy cycles.
    task automatic run_op(input logic [3:0] m, input logic [3:0] q,
                          output logic [7:0] prod, output int lat, output int bcyc);
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat  = -1;
        bcyc = 0;
        prod = 8'h00;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) bcyc++;
            if (done) begin
                lat  = i;
                prod = product;
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] prod;
        logic [7:0] pv;
        logic [3:0] mv;
        logic [3:0] qv;
        logic [7:0] expv;
        int lat;
        int bcyc;
        int ndone;
        int e;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        start = 1'b0;
        multiplicand = 4'h0;
        multiplier   = 4'h0;

        vecs[0] = '{4'h3, 4'h5, 8'h0F};
        vecs[1] = '{4'hD, 4'h5, 8'hF1};
        vecs[2] = '{4'h7, 4'h8, 8'hC8};
        vecs[3] = '{4'h8, 4'h8, 8'h40};
        vecs[4] = '{4'h0, 4'h0, 8'h00};
        vecs[5] = '{4'hF, 4'hF, 8'h01};
        vecs[6] = '{4'h7, 4'h7, 8'h31};
        vecs[7] = '{4'h1, 4'h8, 8'hF8};
        vecs[8] = '{4'h8, 4'h7, 8'hC8};
        vecs[9] = '{4'h5, 4'hF, 8'hFB};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);

        for (int v = 0; v < 10; v++) begin
            run_op(vecs[v].m, vecs[v].q, prod, lat, bcyc);
            check($sformatf("vec%0d_latency", v), 32'(lat - 1), 32'd4);
            check($sformatf("vec%0d_busy_cycles", v), 32'(bcyc), 32'd4);
            check($sformatf("vec%0d_product", v), 32'(prod), 32'(vecs[v].exp));
            @(negedge clk);
            check($sformatf("vec%0d_done_width", v), 32'(done), 32'd0);
        end

        // start pulse while busy is ignored; then restart in the done cycle
        @(negedge clk);
        multiplicand = 4'h2;
        multiplier   = 4'h3;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        multiplicand = 4'h7;
        multiplier   = 4'h7;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 3; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        check("busy_start_latency", 32'(lat - 1), 32'd4);
        check("busy_start_product", 32'(product), 32'h06);
        multiplicand = 4'hF;
        multiplier   = 4'hF;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("restart_single_pulse", 32'(done), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_product_held", 32'(product), 32'h06);
        lat = -1;
        for (int i = 2; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        check("restart_latency", 32'(lat - 1), 32'd4);
        check("restart_product", 32'(product), 32'h01);

        // reset at the second CALC edge aborts without a done pulse
        @(negedge clk);
        multiplicand = 4'h5;
        multiplier   = 4'h5;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);

        // all 256 operand pairs back to back with start held high
        start = 1'b1;
        for (int p = 0; p < 256; p++) begin
            pv = 8'(p);
            mv = pv[7:4];
            qv = pv[3:0];
            multiplicand = mv;
            multiplier   = qv;
            e    = int'($signed(mv)) * int'($signed(qv));
            expv = e[7:0];
            lat  = -1;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (i == 1) check($sformatf("sweep%0d_done_width", p), 32'(done), 32'd0);
                if (done) begin
                    lat = i;
                    break;
                end
            end
            check($sformatf("sweep%0d_latency", p), 32'(lat - 1), 32'd4);
            check($sformatf("sweep%0d_product", p), 32'(product), 32'(expv));
        end
        start = 1'b0;
        @(negedge clk);
        check("sweep_final_done_width", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Sequential signed radix-2 Booth multiplier.
- Sits directly downstream of, and drives, the ripple add/subtract unit (operands a, b; mode m: 0 = add, 1 = subtract via b XOR m with carry-in m).
- Each iteration issues one add, subtract or no-op on the partial-product accumulator, followed by an arithmetic right shift. After WIDTH iterations it delivers a 2*WIDTH-bit two's-complement product with a start/busy/done handshake.

Parameters:
- WIDTH, 4, operand width in bits (two's complement); WIDTH >= 2.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- multiplicand  input  WIDTH  signed operand M, sampled with start
- multiplier  input  WIDTH  signed operand Q, sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when product is valid
- product  output  2*WIDTH  signed result, held until next completion

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset values: busy=0, done=0, product=0, state=IDLE, internal A/Q/q_1/count=0. rst overrides all other inputs on the same edge.
- Internal registers:
  - A: WIDTH+1 bits, signed accumulator; the extra bit absorbs the -2^(WIDTH-1) multiplicand case.
  - Mx: WIDTH+1 bits, sign-extended multiplicand.
  - Q: WIDTH bits.
  - q_1: 1 bit.
  - count: clog2(WIDTH+1) bits.
- States: IDLE, CALC.
- IDLE:
  - done=0 except for the completion pulse.
  - If start=1 at edge k: Mx<=sext(multiplicand), Q<=multiplier, A<=0, q_1<=0, count<=WIDTH, busy<=1, state<=CALC.
- CALC, one iteration per edge:
  - {Q[0],q_1}=01 -> A' = A + Mx (mode 0).
  - {Q[0],q_1}=10 -> A' = A + ~Mx + 1 (mode 1).
  - 00 or 11 -> A' = A.
  - Then arithmetic right shift of {A',Q,q_1}, replicating the MSB of A'; count decrements.
- Completion:
  - On the edge where count goes 1->0 (edge k+WIDTH): product<=low 2*WIDTH bits of the shifted {A,Q}, done<=1, busy<=0, state<=IDLE.
  - Latency: done is high in the cycle after edge k+WIDTH, i.e. WIDTH cycles after the start edge.
  - done is exactly one cycle wide; it clears on the next edge unless a new completion occurs.
- start while busy=1: ignored; operands are not resampled and the current operation is unaffected.
- start high in the cycle done=1: accepted (state is IDLE); product keeps the previous result until the new completion.
- start held high continuously: back-to-back operations, one every WIDTH+1 cycles.
- Operand changes while busy: no effect (latched at start).
- Arithmetic: add/sub results are WIDTH+1 bits, carry-out discarded. No overflow is possible for any pair of WIDTH-bit signed operands, including (-2^(W-1))*(-2^(W-1)) = +2^(2W-2).
- rst mid-CALC: abort; next cycle busy=0, done=0, product=0; no done pulse for the aborted operation.

Test Plan:
- Reset, then start with M=3, Q=5 -> busy high for 4 cycles, done pulse 4 cycles after the start edge, product=8'h0F.
- M=-3 (4'hD), Q=5 -> product=8'hF1 (-15). M=7, Q=-8 (4'h8) -> product=8'hC8 (-56).
- M=-8, Q=-8 -> product=8'h40 (+64); checks the WIDTH+1 accumulator.
- Start M=2, Q=3, then pulse start with M=7, Q=7 two cycles later while busy -> single done pulse, product=8'h06. Then start in the done cycle with M=-1, Q=-1 -> next product=8'h01.
- Start M=5, Q=5; assert rst for one cycle at the second CALC edge -> busy=0, done=0, product=0, no later done pulse.
- Exhaustive sweep: all 256 signed 4-bit pairs via back-to-back starts -> every product equals the signed reference multiply and every done is exactly one cycle wide.
